ex_mem_reg: RTL and testbench

EX/MEM pipeline register directly downstream of the 64-bit ALU in the pipelined core. Each cycle it captures the ALU result, the zero and overflow flags, the store data and the destination/control bits, and presents them to the MEM stage and the forwarding unit. It supports stall, flush and bubble insertion. It also resolves branch-taken, qualifies the overflow trap, and keeps a saturating count of overflow events.

---
 rtl/ex_mem_reg.sv | 151 +++++++++++++++
 tb/tb_ex_mem_reg.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// ============================================================================
// ex_mem_reg
// ----------------------------------------------------------------------------
// EX/MEM pipeline register. It sits directly behind the 64-bit ALU and hands
// the captured result, store data, branch target, destination register and
// qualified control bits to the MEM stage and the forwarding unit. It also
// resolves branch-taken, raises the overflow trap and keeps a saturating
// count of overflow events.
//
// Parameters
//   XLEN        datapath width (ALU result, store data, branch target)
//   TRAP_ON_OVF 1 = overflow raises ovf_exc and kills side effects,
//               0 = overflow is only counted
//   CNT_W       width of the overflow event counter
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall, flush        hold everything / replace the capture with a bubble
//   in_valid            EX stage holds a real instruction
//   alu_result, alu_zero, alu_overflow   ALU outputs
//   rs2_data, branch_target, rd_in       data fields from EX
//   reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in
//                       decoded control from EX
//   out_valid           MEM stage holds a real instruction
//   mem_alu_result, mem_store_data, mem_branch_target, mem_rd
//                       registered data fields (mem_alu_result also forwards)
//   mem_reg_write, mem_read, mem_write, mem_to_reg   qualified control
//   branch_taken        registered branch resolution
//   ovf_exc             registered overflow trap
//   ovf_count           saturating overflow event count
// ============================================================================
module ex_mem_reg #(
    parameter int XLEN        = 64,
    parameter bit TRAP_ON_OVF = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  branch_target,
    input  logic [4:0]       rd_in,
    input  logic             reg_write_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             mem_to_reg_in,
    input  logic             branch_in,
    output logic             out_valid,
    output logic [XLEN-1:0]  mem_alu_result,
    output logic [XLEN-1:0]  mem_store_data,
    output logic [XLEN-1:0]  mem_branch_target,
    output logic [4:0]       mem_rd,
    output logic             mem_reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             branch_taken,
    output logic             ovf_exc,
    output logic [CNT_W-1:0] ovf_count
);

    logic             r_valid;
    logic [XLEN-1:0]  r_aluResult;
    logic [XLEN-1:0]  r_storeData;
    logic [XLEN-1:0]  r_branchTarget;
    logic [4:0]       r_rd;
    logic             r_regWrite;
    logic             r_memRead;
    logic             r_memWrite;
    logic             r_memToReg;
    logic             r_branchTaken;
    logic             r_ovfExc;
    logic [CNT_W-1:0] r_ovfCount;

    logic             w_suppress;
    logic             w_ovfEvent;
    logic             w_cntSat;

    // A trapping overflow must not write the register file or memory.
    // mem_to_reg only selects the writeback mux, so it is left ungated.
    assign w_suppress = TRAP_ON_OVF & alu_overflow;
    assign w_ovfEvent = in_valid & alu_overflow;
    assign w_cntSat   = &r_ovfCount;

    // Single register bank with priority reset > flush > stall > load.
    // The counter only advances on a load, so a stalled instruction that
    // overflows is counted exactly once, when it finally moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid        <= 1'b0;
            r_aluResult    <= '0;
            r_storeData    <= '0;
            r_branchTarget <= '0;
            r_rd           <= '0;
            r_regWrite     <= 1'b0;
            r_memRead      <= 1'b0;
            r_memWrite     <= 1'b0;
            r_memToReg     <= 1'b0;
            r_branchTaken  <= 1'b0;
            r_ovfExc       <= 1'b0;
            r_ovfCount     <= '0;
        end else if (flush) begin
            r_valid        <= 1'b0;
            r_aluResult    <= '0;
            r_storeData    <= '0;
            r_branchTarget <= '0;
            r_rd           <= '0;
            r_regWrite     <= 1'b0;
            r_memRead      <= 1'b0;
            r_memWrite     <= 1'b0;
            r_memToReg     <= 1'b0;
            r_branchTaken  <= 1'b0;
            r_ovfExc       <= 1'b0;
        end else if (!stall) begin
            r_valid        <= in_valid;
            r_aluResult    <= alu_result;
            r_storeData    <= rs2_data;
            r_branchTarget <= branch_target;
            r_rd           <= rd_in;
            // x0 is hardwired to zero, so a write to it is dropped here.
            r_regWrite     <= in_valid & reg_write_in & ~w_suppress & (rd_in != 5'd0);
            r_memRead      <= in_valid & mem_read_in  & ~w_suppress;
            r_memWrite     <= in_valid & mem_write_in & ~w_suppress;
            r_memToReg     <= in_valid & mem_to_reg_in;
            r_branchTaken  <= in_valid & branch_in & alu_zero;
            r_ovfExc       <= in_valid & alu_overflow & TRAP_ON_OVF;
            if (w_ovfEvent && !w_cntSat) begin
                r_ovfCount <= r_ovfCount + 1'b1;
            end
        end
    end

    assign out_valid         = r_valid;
    assign mem_alu_result    = r_aluResult;
    assign mem_store_data    = r_storeData;
    assign mem_branch_target = r_branchTarget;
    assign mem_rd            = r_rd;
    assign mem_reg_write     = r_regWrite;
    assign mem_read          = r_memRead;
    assign mem_write         = r_memWrite;
    assign mem_to_reg        = r_memToReg;
    assign branch_taken      = r_branchTaken;
    assign ovf_exc           = r_ovfExc;
    assign ovf_count         = r_ovfCount;

endmodule

// File: tb/tb_ex_mem_reg.sv
// ============================================================================
// tb_ex_mem_reg
// ----------------------------------------------------------------------------
// Bench for ex_mem_reg. Two copies share one set of inputs: dutA uses the
// defaults (trap on overflow, 16-bit counter), dutB is built with
// TRAP_ON_OVF=0 and CNT_W=2 so counter saturation is reachable quickly.
// Each driven cycle the expected register contents of both copies are
// computed from the inputs and queued; after the clock edge the entry is
// popped and compared against the outputs.
// ============================================================================
module tb_ex_mem_reg;

    typedef struct packed {
        logic        valid;
        logic [63:0] res;
        logic [63:0] st;
        logic [63:0] bt;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        taken;
        logic        exc;
        logic [15:0] cnt;
    } expState_t;

    typedef struct packed {
        expState_t a;
        expState_t b;
    } expPair_t;

    logic clk;
    logic inReset, inStall, inFlush, inValid;
    logic [63:0] inRes, inSt, inBt;
    logic inZero, inOvf;
    logic [4:0] inRd;
    logic inRw, inMr, inMw, inM2r, inBr;

    logic        aValid, aRw, aMr, aMw, aM2r, aTaken, aExc;
    logic [63:0] aRes, aSt, aBt;
    logic [4:0]  aRd;
    logic [15:0] aCnt;

    logic        bValid, bRw, bMr, bMw, bM2r, bTaken, bExc;
    logic [63:0] bRes, bSt, bBt;
    logic [4:0]  bRd;
    logic [1:0]  bCnt;

    expState_t modelA;
    expState_t modelB;
    expPair_t  sbQ[$];

    int errorCount = 0;
    int checkCount = 0;

    ex_mem_reg dutA (
        .clk(clk), .reset(inReset), .stall(inStall), .flush(inFlush),
        .in_valid(inValid), .alu_result(inRes), .alu_zero(inZero),
        .alu_overflow(inOvf), .rs2_data(inSt), .branch_target(inBt),
        .rd_in(inRd), .reg_write_in(inRw), .mem_read_in(inMr),
        .mem_write_in(inMw), .mem_to_reg_in(inM2r), .branch_in(inBr),
        .out_valid(aValid), .mem_alu_result(aRes), .mem_store_data(aSt),
        .mem_branch_target(aBt), .mem_rd(aRd), .mem_reg_write(aRw),
        .mem_read(aMr), .mem_write(aMw), .mem_to_reg(aM2r),
        .branch_taken(aTaken), .ovf_exc(aExc), .ovf_count(aCnt)
    );

    ex_mem_reg #(.XLEN(64), .TRAP_ON_OVF(1'b0), .CNT_W(2)) dutB (
        .clk(clk), .reset(inReset), .stall(inStall), .flush(inFlush),
        .in_valid(inValid), .alu_result(inRes), .alu_zero(inZero),
        .alu_overflow(inOvf), .rs2_data(inSt), .branch_target(inBt),
        .rd_in(inRd), .reg_write_in(inRw), .mem_read_in(inMr),
        .mem_write_in(inMw), .mem_to_reg_in(inM2r), .branch_in(inBr),
        .out_valid(bValid), .mem_alu_result(bRes), .mem_store_data(bSt),
        .mem_branch_target(bBt), .mem_rd(bRd), .mem_reg_write(bRw),
        .mem_read(bMr), .mem_write(bMw), .mem_to_reg(bM2r),
        .branch_taken(bTaken), .ovf_exc(bExc), .ovf_count(bCnt)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next register contents for one copy, given its current contents,
    // its trap setting and the largest value its counter can hold.
    function automatic expState_t modelStep(input expState_t cur, input bit trap,
                                            input int unsigned cntMax);
        expState_t n;
        bit        sup;
        n   = cur;
        sup = trap & inOvf;
        if (inReset) begin
            n = '0;
        end else if (inFlush) begin
            n     = '0;
            n.cnt = cur.cnt;
        end else if (!inStall) begin
            n.valid = inValid;
            n.res   = inRes;
            n.st    = inSt;
            n.bt    = inBt;
            n.rd    = inRd;
            n.rw    = inValid & inRw & ~sup & (inRd != 5'd0);
            n.mr    = inValid & inMr & ~sup;
            n.mw    = inValid & inMw & ~sup;
            n.m2r   = inValid & inM2r;
            n.taken = inValid & inBr & inZero;
            n.exc   = inValid & inOvf & trap;
            if (inValid && inOvf && (cur.cnt < cntMax)) n.cnt = cur.cnt + 16'd1;
        end
        return n;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Compare every output of both copies against one scoreboard entry.
    task automatic compareAll(input expPair_t e);
        checkOutput("A.valid", {63'd0, aValid}, {63'd0, e.a.valid});
        checkOutput("A.res",   aRes, e.a.res);
        checkOutput("A.st",    aSt,  e.a.st);
        checkOutput("A.bt",    aBt,  e.a.bt);
        checkOutput("A.rd",    {59'd0, aRd}, {59'd0, e.a.rd});
        checkOutput("A.rw",    {63'd0, aRw}, {63'd0, e.a.rw});
        checkOutput("A.mr",    {63'd0, aMr}, {63'd0, e.a.mr});
        checkOutput("A.mw",    {63'd0, aMw}, {63'd0, e.a.mw});
        checkOutput("A.m2r",   {63'd0, aM2r}, {63'd0, e.a.m2r});
        checkOutput("A.taken", {63'd0, aTaken}, {63'd0, e.a.taken});
        checkOutput("A.exc",   {63'd0, aExc}, {63'd0, e.a.exc});
        checkOutput("A.cnt",   {48'd0, aCnt}, {48'd0, e.a.cnt});
        checkOutput("B.valid", {63'd0, bValid}, {63'd0, e.b.valid});
        checkOutput("B.res",   bRes, e.b.res);
        checkOutput("B.rd",    {59'd0, bRd}, {59'd0, e.b.rd});
        checkOutput("B.rw",    {63'd0, bRw}, {63'd0, e.b.rw});
        checkOutput("B.mr",    {63'd0, bMr}, {63'd0, e.b.mr});
        checkOutput("B.mw",    {63'd0, bMw}, {63'd0, e.b.mw});
        checkOutput("B.m2r",   {63'd0, bM2r}, {63'd0, e.b.m2r});
        checkOutput("B.taken", {63'd0, bTaken}, {63'd0, e.b.taken});
        checkOutput("B.exc",   {63'd0, bExc}, {63'd0, e.b.exc});
        checkOutput("B.cnt",   {62'd0, bCnt}, {48'd0, e.b.cnt});
    endtask

    // Drive the current inputs for one cycle: queue the expected result,
    // let the edge happen, then pop and compare just after it.
    task automatic applyStimulus();
        expPair_t e;
        modelA = modelStep(modelA, 1'b1, 32'd65535);
        modelB = modelStep(modelB, 1'b0, 32'd3);
        sbQ.push_back('{a: modelA, b: modelB});
        @(posedge clk);
        #1;
        if (sbQ.size() == 0) begin
            checkOutput("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sbQ.pop_front();
            compareAll(e);
        end
    endtask

    task automatic setIdle();
        inReset = 1'b0; inStall = 1'b0; inFlush = 1'b0; inValid = 1'b0;
        inRes = '0; inSt = '0; inBt = '0; inZero = 1'b0; inOvf = 1'b0;
        inRd = '0; inRw = 1'b0; inMr = 1'b0; inMw = 1'b0; inM2r = 1'b0; inBr = 1'b0;
    endtask

    initial begin
        modelA = '0;
        modelB = '0;
        setIdle();
        inReset = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("tp_reset_cnt", {48'd0, aCnt}, 64'd0);

        // Simple ALU result load.
        setIdle();
        inValid = 1'b1; inRes = 64'd30; inRd = 5'd5; inRw = 1'b1; inSt = 64'h55;
        applyStimulus();
        checkOutput("tp_load_res", aRes, 64'd30);
        checkOutput("tp_load_rw", {63'd0, aRw}, 64'd1);

        // Overflow: trapped in dutA, only counted in dutB.
        setIdle();
        inValid = 1'b1; inRes = 64'h8000000000000000; inOvf = 1'b1;
        inRw = 1'b1; inMw = 1'b1; inRd = 5'd7;
        applyStimulus();
        checkOutput("tp_ovf_exc", {63'd0, aExc}, 64'd1);
        checkOutput("tp_ovf_mw", {63'd0, aMw}, 64'd0);
        checkOutput("tp_ovf_cnt", {48'd0, aCnt}, 64'd1);

        // Branch resolved taken, then not taken.
        setIdle();
        inValid = 1'b1; inBr = 1'b1; inZero = 1'b1; inBt = 64'h1000;
        applyStimulus();
        checkOutput("tp_br_taken", {63'd0, aTaken}, 64'd1);
        inZero = 1'b0;
        applyStimulus();
        checkOutput("tp_br_not", {63'd0, aTaken}, 64'd0);

        // Load, then three stall cycles with changing inputs and overflow.
        setIdle();
        inValid = 1'b1; inRes = 64'hABCD; inRd = 5'd9; inRw = 1'b1; inMr = 1'b1; inM2r = 1'b1;
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            inStall = 1'b1; inOvf = 1'b1; inRes = 64'(i + 100); inRd = 5'(i + 20);
            applyStimulus();
        end
        checkOutput("tp_stall_res", aRes, 64'hABCD);
        checkOutput("tp_stall_cnt", {48'd0, aCnt}, 64'd1);

        // Stall and flush together: flush wins.
        setIdle();
        inStall = 1'b1; inFlush = 1'b1; inValid = 1'b1; inRw = 1'b1; inRd = 5'd3; inMw = 1'b1;
        applyStimulus();
        checkOutput("tp_flush_valid", {63'd0, aValid}, 64'd0);

        // Write to x0 is dropped.
        setIdle();
        inValid = 1'b1; inRw = 1'b1; inRd = 5'd0; inRes = 64'd77;
        applyStimulus();
        checkOutput("tp_x0_rw", {63'd0, aRw}, 64'd0);

        // Overflowing load: mem_read gated, mem_to_reg passes in dutA.
        setIdle();
        inValid = 1'b1; inOvf = 1'b1; inMr = 1'b1; inM2r = 1'b1; inRd = 5'd4; inRw = 1'b1;
        applyStimulus();

        // Bubble.
        setIdle();
        inRw = 1'b1; inMw = 1'b1; inRd = 5'd6; inBr = 1'b1; inZero = 1'b1;
        applyStimulus();

        // Counter saturation on the 2-bit copy: 1,2,3,3,3.
        setIdle();
        inReset = 1'b1;
        applyStimulus();
        for (int i = 0; i < 5; i++) begin
            setIdle();
            inValid = 1'b1; inOvf = 1'b1; inRd = 5'd1; inRw = 1'b1;
            applyStimulus();
            checkOutput("tp_sat_cnt", {62'd0, bCnt}, (i < 3) ? 64'(i + 1) : 64'd3);
        end
        setIdle();
        inReset = 1'b1; inStall = 1'b1; inFlush = 1'b1;
        applyStimulus();
        checkOutput("tp_sat_reset", {62'd0, bCnt}, 64'd0);

        // Random mix of loads, stalls, flushes and occasional resets.
        for (int i = 0; i < 60; i++) begin
            inReset = ($urandom_range(0, 19) == 0);
            inStall = ($urandom_range(0, 3) == 0);
            inFlush = ($urandom_range(0, 7) == 0);
            inValid = $urandom_range(0, 1);
            inRes   = {$urandom, $urandom};
            inSt    = {$urandom, $urandom};
            inBt    = {$urandom, $urandom};
            inZero  = $urandom_range(0, 1);
            inOvf   = $urandom_range(0, 1);
            inRd    = 5'($urandom_range(0, 31));
            inRw    = $urandom_range(0, 1);
            inMr    = $urandom_range(0, 1);
            inMw    = $urandom_range(0, 1);
            inM2r   = $urandom_range(0, 1);
            inBr    = $urandom_range(0, 1);
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
